// File: rtl/inst_rom_arbiter_pkg.sv
// Shared types and constants for the inst_rom read-port arbiter.
// Covers the FSM state codes, owner encodings, bus widths and ROM control levels.
package inst_rom_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WAIT_W = 3;   // holds ROM_WAIT up to 7
    localparam int FAIR_W = 4;   // holds MAX_MEM_BURST up to 15

    localparam logic [DATA_W-1:0] ZERO_WORD    = '0;
    localparam logic              CHIP_ENABLE  = 1'b1;
    localparam logic              CHIP_DISABLE = 1'b0;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_MEM = 1'b1
    } owner_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_rom_arbiter.sv
// Shares the single inst_rom read port between instruction fetch and the MEM stage.
// Each access takes ROM_WAIT+2 cycles from grant to registered read data.
module inst_rom_arbiter
    import inst_rom_arbiter_pkg::*;
#(
    parameter int ROM_WAIT      = 0,
    parameter int MAX_MEM_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              mem_req,
    input  logic [ADDR_W-1:0] mem_addr,
    output logic              mem_gnt,
    output logic              mem_rvalid,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_misalign,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst,
    output logic              stallreq_if,
    output logic              stallreq_mem
);

    localparam logic [WAIT_W-1:0] WAIT_INIT  = WAIT_W'(ROM_WAIT);
    localparam logic [FAIR_W-1:0] FAIR_LIMIT = FAIR_W'(MAX_MEM_BURST);

    arb_state_t        state, state_nxt;
    owner_t            owner;
    logic              misalign_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [FAIR_W-1:0] fair_cnt;
    logic              if_forced;
    logic              grant_any;
    logic              access_done;

    // MEM normally wins; IF is forced once MEM has won MAX_MEM_BURST times in a row over it.
    // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        if_gnt      = 1'b0;
        mem_gnt     = 1'b0;
        if_forced   = if_req && (fair_cnt == FAIR_LIMIT);
        access_done = (state == ARB_BUSY) && (wait_cnt == '0);
        if (!rst && state == ARB_IDLE) begin
            if (mem_req && !if_forced) begin
                mem_gnt = 1'b1;
            end else if (if_req) begin
                if_gnt = 1'b1;
            end
        end
        grant_any = if_gnt || mem_gnt;
        if (grant_any) begin
            state_nxt = ARB_BUSY;
        end else if (access_done) begin
            state_nxt = ARB_IDLE;
        end
    end

    assign stallreq_if  = if_req  && !if_gnt;
    assign stallreq_mem = mem_req && !mem_gnt;

    // NOTE: sequential state uses <= only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner        <= OWNER_IF;
            misalign_q   <= 1'b0;
            wait_cnt     <= '0;
            fair_cnt     <= '0;
            rom_ce       <= CHIP_DISABLE;
            rom_addr     <= ZERO_WORD;
            if_rdata     <= ZERO_WORD;
            mem_rdata    <= ZERO_WORD;
            if_rvalid    <= 1'b0;
            mem_rvalid   <= 1'b0;
            mem_misalign <= 1'b0;
        end else begin
            if_rvalid    <= 1'b0;
            mem_rvalid   <= 1'b0;
            mem_misalign <= 1'b0;

            // Grants only happen in IDLE, so the grant and BUSY branches never overlap.
            if (grant_any) begin
                owner      <= mem_gnt ? OWNER_MEM : OWNER_IF;
                misalign_q <= mem_gnt && (mem_addr[1:0] != 2'b00);
                rom_addr   <= word_align(mem_gnt ? mem_addr : if_addr);
                rom_ce     <= CHIP_ENABLE;
                wait_cnt   <= WAIT_INIT;
            end else if (state == ARB_BUSY) begin
                if (access_done) begin
                    rom_ce <= CHIP_DISABLE;
                    if (owner == OWNER_MEM) begin
                        mem_rdata    <= rom_inst;
                        mem_rvalid   <= 1'b1;
                        mem_misalign <= misalign_q;
                    end else begin
                        if_rdata  <= rom_inst;
                        if_rvalid <= 1'b1;
                    end
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end

            // Counts MEM wins only while IF is actually waiting.
            if (!if_req || if_gnt) begin
                fair_cnt <= '0;
            end else if (mem_gnt && fair_cnt != '1) begin
                fair_cnt <= fair_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Self-checking bench for inst_rom_arbiter: directed scenarios plus random traffic,
// compared every cycle against a timestamp-based reference model.
module tb_inst_rom_arbiter;

    localparam int ROM_WAIT      = 2;
    localparam int MAX_MEM_BURST = 4;
    localparam byte CH_M = 8'h4D;
    localparam byte CH_I = 8'h49;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req;
    logic [31:0] if_addr, mem_addr;
    logic        if_gnt, if_rvalid, mem_gnt, mem_rvalid, mem_misalign;
    logic [31:0] if_rdata, mem_rdata;
    logic        rom_ce;
    logic [31:0] rom_addr, rom_inst;
    logic        stallreq_if, stallreq_mem;

    logic [31:0] rom_mem [256];

    always #5 clk = ~clk;

    assign rom_inst = rom_mem[rom_addr[9:2]];

    inst_rom_arbiter #(
        .ROM_WAIT      (ROM_WAIT),
        .MAX_MEM_BURST (MAX_MEM_BURST)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rvalid    (if_rvalid),
        .if_rdata     (if_rdata),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .mem_misalign (mem_misalign),
        .rom_ce       (rom_ce),
        .rom_addr     (rom_addr),
        .rom_inst     (rom_inst),
        .stallreq_if  (stallreq_if),
        .stallreq_mem (stallreq_mem)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // Reference model: an access granted in cycle T occupies the port until T+ROM_WAIT+2.
    int          free_at = 0;
    int          ce_from = -1;
    int          ce_to   = -2;
    int          done_at = -1;
    bit          done_mem;
    bit          done_mis;
    logic [31:0] done_addr;
    logic [31:0] m_rom_addr  = '0;
    logic [31:0] m_if_rdata  = '0;
    logic [31:0] m_mem_rdata = '0;
    int          burst = 0;

    bit m_if_gnt, m_mem_gnt;
    bit d_if_gnt, d_mem_gnt, d_rom_ce, d_mem_rvalid, d_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check at negedge, then advance the model.
    task automatic tick();
        bit          idle, e_rv_if, e_rv_mem;
        logic [31:0] a;
        @(negedge clk);
        idle      = !rst && (cyc >= free_at);
        m_mem_gnt = idle && mem_req && !(if_req && burst == MAX_MEM_BURST);
        m_if_gnt  = idle && if_req && !m_mem_gnt;
        e_rv_if   = (cyc == done_at) && !done_mem;
        e_rv_mem  = (cyc == done_at) && done_mem;
        if (e_rv_if)  m_if_rdata  = rom_mem[done_addr[9:2]];
        if (e_rv_mem) m_mem_rdata = rom_mem[done_addr[9:2]];

        check("if_gnt",       if_gnt,       m_if_gnt);
        check("mem_gnt",      mem_gnt,      m_mem_gnt);
        check("stallreq_if",  stallreq_if,  if_req && !m_if_gnt);
        check("stallreq_mem", stallreq_mem, mem_req && !m_mem_gnt);
        check("if_rvalid",    if_rvalid,    e_rv_if);
        check("mem_rvalid",   mem_rvalid,   e_rv_mem);
        check("mem_misalign", mem_misalign, e_rv_mem && done_mis);
        check("rom_ce",       rom_ce,       (cyc >= ce_from) && (cyc <= ce_to));
        check("rom_addr",     rom_addr,     m_rom_addr);
        check("if_rdata",     if_rdata,     m_if_rdata);
        check("mem_rdata",    mem_rdata,    m_mem_rdata);

        d_if_gnt     = if_gnt;
        d_mem_gnt    = mem_gnt;
        d_rom_ce     = rom_ce;
        d_mem_rvalid = mem_rvalid;
        d_mis        = mem_misalign;

        if (rst) begin
            free_at     = cyc + 1;
            ce_from     = -1;
            ce_to       = -2;
            done_at     = -1;
            m_rom_addr  = '0;
            m_if_rdata  = '0;
            m_mem_rdata = '0;
            burst       = 0;
        end else begin
            if (m_if_gnt || m_mem_gnt) begin
                a          = m_mem_gnt ? mem_addr : if_addr;
                ce_from    = cyc + 1;
                ce_to      = cyc + 1 + ROM_WAIT;
                done_at    = cyc + ROM_WAIT + 2;
                free_at    = done_at;
                done_mem   = m_mem_gnt;
                done_addr  = {a[31:2], 2'b00};
                done_mis   = m_mem_gnt && (a[1:0] != 2'b00);
                m_rom_addr = done_addr;
            end
            if (!if_req || m_if_gnt) burst = 0;
            else if (m_mem_gnt && burst < 15) burst++;
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_gnt(input bit want_mem, output int at);
        at = -1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (want_mem ? d_mem_gnt : d_if_gnt) begin
                at = cyc - 1;
                break;
            end
        end
        check(want_mem ? "mem_gnt_in_budget" : "if_gnt_in_budget", at >= 0, 1'b1);
    endtask

    // Single MEM access: measures grant->rvalid latency, rom_ce width and the misalign flag.
    task automatic mem_access(input logic [31:0] addr, output int lat, output int ce_n, output bit mis);
        int t, rv;
        mem_req  = 1'b1;
        mem_addr = addr;
        wait_gnt(1'b1, t);
        mem_req = 1'b0;
        ce_n = 0;
        rv   = -1;
        mis  = 1'b0;
        for (int k = 0; k < ROM_WAIT + 4; k++) begin
            tick();
            if (d_rom_ce) ce_n++;
            if (d_mem_rvalid && rv < 0) begin
                rv  = cyc - 1;
                mis = d_mis;
            end
        end
        lat = rv - t;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  g0, g1, g2, lat, ce_n, mem_seen, k;
        bit  mis;
        byte gq[$];

        for (int i = 0; i < 256; i++) rom_mem[i] = $urandom;
        rst      = 1'b1;
        if_req   = 1'b1;
        if_addr  = '0;
        mem_req  = 1'b0;
        mem_addr = '0;
        @(posedge clk);
        #1;

        // Reset: no grants, stall mirrors the pending IF request.
        repeat (3) tick();
        rst = 1'b0;

        // Back-to-back IF fetches of words 0,1,2.
        wait_gnt(1'b0, g0);
        if_addr = 32'h4;
        wait_gnt(1'b0, g1);
        if_addr = 32'h8;
        wait_gnt(1'b0, g2);
        if_req = 1'b0;
        check("if_gnt_spacing_1", g1 - g0, ROM_WAIT + 2);
        check("if_gnt_spacing_2", g2 - g1, ROM_WAIT + 2);
        repeat (ROM_WAIT + 3) tick();

        // Aligned, misaligned, then aligned MEM accesses.
        mem_access(32'h10, lat, ce_n, mis);
        check("mem_latency", lat, ROM_WAIT + 2);
        check("rom_ce_width", ce_n, ROM_WAIT + 1);
        check("aligned_misalign", mis, 1'b0);
        mem_access(32'h13, lat, ce_n, mis);
        check("misaligned_flag", mis, 1'b1);
        mem_access(32'h20, lat, ce_n, mis);
        check("realigned_flag", mis, 1'b0);

        // Both ports held: MEM wins MAX_MEM_BURST times, then IF is forced.
        if_req   = 1'b1;
        mem_req  = 1'b1;
        if_addr  = $urandom;
        mem_addr = $urandom;
        for (int n = 0; n < 12 * (ROM_WAIT + 2); n++) begin
            tick();
            if (d_mem_gnt) begin
                gq.push_back(CH_M);
                mem_addr = $urandom;
            end
            if (d_if_gnt) begin
                gq.push_back(CH_I);
                if_addr = $urandom;
            end
        end
        check("grant_count", gq.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < gq.size(); i++)
            check("grant_pattern", gq[i], (i % (MAX_MEM_BURST + 1) == MAX_MEM_BURST) ? CH_I : CH_M);

        // Reset while BUSY with fairness counter at its limit: next grant must go to MEM.
        if_req  = 1'b0;
        mem_req = 1'b0;
        repeat (ROM_WAIT + 3) tick();
        if_req   = 1'b1;
        mem_req  = 1'b1;
        mem_seen = 0;
        k        = 0;
        while (mem_seen < MAX_MEM_BURST && k < 60) begin
            tick();
            k++;
            if (d_mem_gnt) mem_seen++;
        end
        check("burst_reached", mem_seen, MAX_MEM_BURST);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_mem_gnt", d_mem_gnt, 1'b1);
        check("post_rst_if_gnt", d_if_gnt, 1'b0);
        if_req  = 1'b0;
        mem_req = 1'b0;
        repeat (ROM_WAIT + 3) tick();

        // Random traffic with drops, address changes and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (!if_req || m_if_gnt) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                if_addr = $urandom;
            end
            if (!mem_req || m_mem_gnt) begin
                mem_req  = ($urandom_range(0, 2) == 0);
                mem_addr = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                mem_req = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                mem_addr = $urandom;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
